// File: rtl/mix_column_engine.sv
// rtl/mix_column_engine.sv - serial AES MixColumns / InvMixColumns column mixer
//
// Purpose:
//   Mixes one 32-bit AES state column per handshake. The 16 constant
//   products M[r][c] * a_c are formed one multiplier bit per cycle with a
//   Horner shift-and-add in GF(2^8) and XOR-accumulated into the output
//   bytes. A column takes 64 calculation cycles plus one done cycle.
//
// Ports:
//   clk         in   rising-edge clock
//   rst_n       in   asynchronous active-low reset
//   valid       in   start request, sampled only while idle
//   inverse     in   0 = MixColumns, 1 = InvMixColumns (latched with valid)
//   column_in   in   [31:24]=a0 .. [7:0]=a3
//   busy        out  high while calculating and in the done cycle
//   done        out  one-cycle pulse, column_out final in this cycle
//   column_out  out  [31:24]=b0 .. [7:0]=b3

module mix_column_engine (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        valid,
  input  logic        inverse,
  input  logic [31:0] column_in,
  output logic        busy,
  output logic        done,
  output logic [31:0] column_out
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_next;

  logic [31:0] r_a;
  logic        r_mode;
  logic [7:0]  r_p;
  logic [5:0]  r_step;
  logic [31:0] r_out;

  logic [1:0]  w_r;
  logic [1:0]  w_c;
  logic [1:0]  w_k;
  logic [1:0]  w_base_idx;
  logic [1:0]  w_bit_idx;
  logic [1:0]  w_byte_idx;
  logic [3:0]  w_coef;
  logic [7:0]  w_ac;
  logic [7:0]  w_p_prev;
  logic [7:0]  w_p_next;

  // Multiply by x modulo x^8 + x^4 + x^3 + x + 1.
  function automatic logic [7:0] xtime(input logic [7:0] x);
    xtime = {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
  endfunction

  // Step counter layout {row, col, bit}; bit index advances fastest.
  assign w_r = r_step[5:4];
  assign w_c = r_step[3:2];
  assign w_k = r_step[1:0];

  // Circulant matrix: row r is the base row rotated right by r.
  assign w_base_idx = w_c - w_r;
  // Horner walks the 4-bit coefficient from its MSB down.
  assign w_bit_idx  = 2'd3 - w_k;
  // b0 lives in the top byte, so row r maps to byte lane 3-r.
  assign w_byte_idx = 2'd3 - w_r;

  always_comb begin
    w_coef = 4'd0;
    if (r_mode) begin
      case (w_base_idx)
        2'd0:    w_coef = 4'd14;
        2'd1:    w_coef = 4'd11;
        2'd2:    w_coef = 4'd13;
        default: w_coef = 4'd9;
      endcase
    end else begin
      case (w_base_idx)
        2'd0:    w_coef = 4'd2;
        2'd1:    w_coef = 4'd3;
        default: w_coef = 4'd1;
      endcase
    end
  end

  always_comb begin
    w_ac = 8'h00;
    case (w_c)
      2'd0:    w_ac = r_a[31:24];
      2'd1:    w_ac = r_a[23:16];
      2'd2:    w_ac = r_a[15:8];
      default: w_ac = r_a[7:0];
    endcase
  end

  // The first bit of each product starts from zero instead of the
  // previous product's leftover value.
  assign w_p_prev = (w_k == 2'd0) ? 8'h00 : r_p;
  assign w_p_next = xtime(w_p_prev) ^ (w_coef[w_bit_idx] ? w_ac : 8'h00);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: if (valid) w_state_next = S_CALC;
      S_CALC: if (r_step == 6'd63) w_state_next = S_DONE;
      S_DONE: w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a    <= 32'h0;
      r_mode <= 1'b0;
      r_p    <= 8'h00;
      r_step <= 6'd0;
      r_out  <= 32'h0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (valid) begin
            r_a    <= column_in;
            r_mode <= inverse;
            r_p    <= 8'h00;
            r_step <= 6'd0;
            r_out  <= 32'h0;
          end
        end
        S_CALC: begin
          r_p    <= w_p_next;
          r_step <= r_step + 6'd1;
          if (w_k == 2'd3) begin
            r_out[{w_byte_idx, 3'b000} +: 8] <= r_out[{w_byte_idx, 3'b000} +: 8] ^ w_p_next;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy       = (r_state != S_IDLE);
  assign done       = (r_state == S_DONE);
  assign column_out = r_out;

endmodule
